// File: rtl/clk_div_ctrl_if.sv
// Divisor programming handshake between a controller and clk_div_ctrl.
interface clk_div_ctrl_if #(
  parameter int unsigned CNT_W = 28
) ();
  logic [CNT_W-1:0] div_in;
  logic             div_valid;
  logic             div_ready;
  logic             div_err;

  modport master (output div_in, div_valid, input  div_ready, div_err);
  modport slave  (input  div_in, div_valid, output div_ready, div_err);
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable / square-wave generator with glitch-free divisor updates.
// Optional single-period mode is enabled with `define CLK_DIV_CTRL_ONESHOT_EN.
module clk_div_ctrl #(
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned DEFAULT_DIV = 50_000_000,
  parameter int unsigned MIN_DIV     = 2
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             en,
`ifdef CLK_DIV_CTRL_ONESHOT_EN
  input  logic             oneshot,
`endif
  clk_div_ctrl_if.slave    div_bus,
  output logic             tick,
  output logic             clk_out,
  output logic [CNT_W-1:0] cur_div,
  output logic             running
);

  typedef enum logic [1:0] {STOP, RUN, PEND} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             div_ready_q, div_ready_d;
  logic             div_err_q, div_err_d;
  logic             running_q, running_d;
  logic             shot_q, shot_d;   // current run is a single period
  logic             hold_q, hold_d;   // single period done, wait for en to drop

  logic oneshot_i;
`ifdef CLK_DIV_CTRL_ONESHOT_EN
  assign oneshot_i = oneshot;
`else
  assign oneshot_i = 1'b0;
`endif

  logic xfer, legal, take, wrap, stop_req;
  assign xfer     = div_bus.div_valid & div_ready_q;
  assign legal    = div_bus.div_in >= CNT_W'(MIN_DIV);
  assign take     = xfer & legal;
  assign wrap     = cnt_q == (cur_div_q - CNT_W'(1));
  assign stop_req = ~en | shot_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_div_d   = cur_div_q;
    pend_d      = pend_q;
    div_ready_d = div_ready_q;
    shot_d      = shot_q;
    hold_d      = hold_q & en;
    clk_out_d   = 1'b0;
    tick_d      = 1'b0;
    div_err_d   = xfer & ~legal;
    unique case (state_q)
      STOP: begin
        cnt_d = '0;
        if (take) cur_div_d = div_bus.div_in;
        if (en && !hold_q) begin
          state_d = RUN;
          shot_d  = oneshot_i;
        end
      end
      default: begin
        clk_out_d = cnt_q >= (cur_div_q >> 1);
        tick_d    = wrap;
        cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
        if (wrap && state_q == PEND) begin
          cur_div_d   = pend_q;
          div_ready_d = 1'b1;
          state_d     = RUN;
        end
        // A divisor offered on the stopping wrap behaves as if offered in STOP.
        if (wrap && stop_req) begin
          state_d = STOP;
          shot_d  = 1'b0;
          hold_d  = shot_q;
          if (take) cur_div_d = div_bus.div_in;
        end else if (take) begin
          pend_d      = div_bus.div_in;
          div_ready_d = 1'b0;
          state_d     = PEND;
        end
      end
    endcase
    running_d = state_d != STOP;
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_q     <= STOP;
      cnt_q       <= '0;
      cur_div_q   <= CNT_W'(DEFAULT_DIV);
      pend_q      <= '0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      div_ready_q <= 1'b1;
      div_err_q   <= 1'b0;
      running_q   <= 1'b0;
      shot_q      <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_div_q   <= cur_div_d;
      pend_q      <= pend_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      div_ready_q <= div_ready_d;
      div_err_q   <= div_err_d;
      running_q   <= running_d;
      shot_q      <= shot_d;
      hold_q      <= hold_d;
    end
  end

  assign div_bus.div_ready = div_ready_q;
  assign div_bus.div_err   = div_err_q;
  assign tick              = tick_q;
  assign clk_out           = clk_out_q;
  assign cur_div           = cur_div_q;
  assign running           = running_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl against a period-level reference model.
module tb_clk_div_ctrl;
  localparam int W = 28;

  logic clk_50M = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
`ifdef CLK_DIV_CTRL_ONESHOT_EN
  logic oneshot = 1'b0;
`endif
  logic tick, clk_out, running;
  logic [W-1:0] cur_div;

  clk_div_ctrl_if #(.CNT_W(W)) bus ();

  clk_div_ctrl #(.CNT_W(W), .DEFAULT_DIV(10), .MIN_DIV(2)) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .en      (en),
`ifdef CLK_DIV_CTRL_ONESHOT_EN
    .oneshot (oneshot),
`endif
    .div_bus (bus),
    .tick    (tick),
    .clk_out (clk_out),
    .cur_div (cur_div),
    .running (running)
  );

  always #10 clk_50M = ~clk_50M;

  int n_vec = 0, n_bad = 0;
  int cyc = 0, last_tick = 0, per = 0;

  // Reference model: position within the current period, period length, queued divisor.
  bit m_run, m_ready, m_err, m_tick, m_clk, m_qv;
  int m_ph, m_d, m_qd;

  task automatic model_reset();
    m_run = 0; m_ready = 1; m_err = 0; m_tick = 0; m_clk = 0; m_qv = 0;
    m_ph = 0; m_d = 10; m_qd = 0;
  endtask

  task automatic model_edge();
    bit xfer, ok, wrap;
    int din;
    din  = int'(bus.div_in);
    xfer = bus.div_valid && m_ready;
    ok   = xfer && din >= 2;
    m_err = xfer && din < 2;
    if (!m_run) begin
      m_clk = 0; m_tick = 0;
      if (ok) m_d = din;
      if (en) begin m_run = 1; m_ph = 0; end
    end else begin
      wrap   = (m_ph == m_d - 1);
      m_clk  = (m_ph >= m_d / 2);
      m_tick = wrap;
      m_ph   = wrap ? 0 : m_ph + 1;
      if (wrap && m_qv) begin m_d = m_qd; m_qv = 0; m_ready = 1; end
      if (wrap && !en) begin
        m_run = 0; m_ph = 0;
        if (ok) m_d = din;
      end else if (ok) begin
        m_qd = din; m_qv = 1; m_ready = 0;
      end
    end
  endtask

  function automatic logic [W+4:0] mvec();
    return {m_tick, m_clk, m_ready, m_err, m_run, W'(m_d)};
  endfunction

  function automatic logic [W+4:0] dvec();
    return {tick, clk_out, bus.div_ready, bus.div_err, running, cur_div};
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk_50M);
    #1;
    cyc++;
    if (tick) begin per = cyc - last_tick; last_tick = cyc; end
  endtask

  task automatic apply_reset();
    rst = 1; en = 0; bus.div_valid = 0; bus.div_in = '0;
    model_reset();
    repeat (2) @(posedge clk_50M);
    #1;
    rst = 0; cyc = 0; last_tick = 0; per = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (dvec() !== mvec()) begin
      n_bad++; $display("FAIL reset_state got=%h exp=%h", dvec(), mvec());
    end
    n_vec++;
    if ({tick, clk_out, bus.div_ready, bus.div_err, running} !== 5'b00100 || cur_div !== W'(10)) begin
      n_bad++; $display("FAIL reset_outputs got=%b div=%0d exp=00100 div=10",
        {tick, clk_out, bus.div_ready, bus.div_err, running}, cur_div);
    end
  endtask

  task automatic test_free_run();
    bit et, ec;
    en = 1;
    for (int e = 0; e <= 30; e++) begin
      step();
      n_vec++;
      if (dvec() !== mvec()) begin
        n_bad++; $display("FAIL free_run_model edge=%0d got=%h exp=%h", e, dvec(), mvec());
      end
      et = (e > 0) && (e % 10 == 0);
      ec = (e > 0) && (((e - 1) % 10) >= 5);
      n_vec++;
      if ({tick, clk_out, running} !== {et, ec, 1'b1}) begin
        n_bad++; $display("FAIL free_run_wave edge=%0d got=%b exp=%b", e, {tick, clk_out, running}, {et, ec, 1'b1});
      end
    end
  endtask

  task automatic test_illegal();
    step();
    bus.div_valid = 1; bus.div_in = W'(1);
    step();
    bus.div_valid = 0;
    n_vec++;
    if ({bus.div_err, bus.div_ready} !== 2'b11 || cur_div !== W'(10)) begin
      n_bad++; $display("FAIL illegal_err got err/rdy=%b div=%0d exp=11 div=10", {bus.div_err, bus.div_ready}, cur_div);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      n_vec++;
      if (dvec() !== mvec()) begin
        n_bad++; $display("FAIL illegal_model k=%0d got=%h exp=%h", k, dvec(), mvec());
      end
    end
    n_vec++;
    if (tick !== 1'b1 || per !== 10 || bus.div_err !== 1'b0) begin
      n_bad++; $display("FAIL illegal_period got tick=%b per=%0d err=%b exp tick=1 per=10 err=0", tick, per, bus.div_err);
    end
  endtask

  task automatic test_reprogram();
    repeat (3) step();
    bus.div_valid = 1; bus.div_in = W'(4);
    step();
    bus.div_valid = 0;
    n_vec++;
    if (bus.div_ready !== 1'b0 || cur_div !== W'(10)) begin
      n_bad++; $display("FAIL reprog_accept got rdy=%b div=%0d exp rdy=0 div=10", bus.div_ready, cur_div);
    end
    for (int e = 45; e <= 58; e++) begin
      step();
      n_vec++;
      if (dvec() !== mvec()) begin
        n_bad++; $display("FAIL reprog_model edge=%0d got=%h exp=%h", e, dvec(), mvec());
      end
      n_vec++;
      if (bus.div_ready !== (e >= 50) || tick !== (e == 50 || e == 54 || e == 58)) begin
        n_bad++; $display("FAIL reprog_timing edge=%0d got rdy=%b tick=%b", e, bus.div_ready, tick);
      end
      if (e == 50 || e == 54 || e == 58) begin
        n_vec++;
        if (per !== (e == 50 ? 10 : 4)) begin
          n_bad++; $display("FAIL reprog_period edge=%0d got=%0d exp=%0d", e, per, (e == 50 ? 10 : 4));
        end
      end
    end
  endtask

  task automatic test_odd_stop();
    apply_reset();
    bus.div_valid = 1; bus.div_in = W'(7);
    step();
    bus.div_valid = 0;
    n_vec++;
    if (cur_div !== W'(7) || running !== 1'b0) begin
      n_bad++; $display("FAIL odd_load got div=%0d run=%b exp div=7 run=0", cur_div, running);
    end
    en = 1;
    step();
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 3) en = 0;
      n_vec++;
      if ({clk_out, tick, running} !== {((k - 1) >= 3), (k == 7), (k < 7)}) begin
        n_bad++; $display("FAIL odd_phase k=%0d got=%b exp=%b", k, {clk_out, tick, running},
          {((k - 1) >= 3), (k == 7), (k < 7)});
      end
      n_vec++;
      if (dvec() !== mvec()) begin
        n_bad++; $display("FAIL odd_model k=%0d got=%h exp=%h", k, dvec(), mvec());
      end
    end
    for (int k = 0; k < 10; k++) begin
      step();
      n_vec++;
      if ({clk_out, tick, running} !== 3'b000) begin
        n_bad++; $display("FAIL odd_stopped k=%0d got=%b exp=000", k, {clk_out, tick, running});
      end
    end
  endtask

  task automatic test_reset_pend();
    apply_reset();
    en = 1;
    repeat (4) step();
    bus.div_valid = 1; bus.div_in = W'(6);
    step();
    bus.div_valid = 0;
    n_vec++;
    if (bus.div_ready !== 1'b0) begin
      n_bad++; $display("FAIL pend_ready got=%b exp=0", bus.div_ready);
    end
    step();
    #3 rst = 1;
    #1;
    n_vec++;
    if ({tick, clk_out, bus.div_ready, bus.div_err, running} !== 5'b00100 || cur_div !== W'(10)) begin
      n_bad++; $display("FAIL async_reset got=%b div=%0d exp=00100 div=10",
        {tick, clk_out, bus.div_ready, bus.div_err, running}, cur_div);
    end
    model_reset();
    @(posedge clk_50M);
    #1;
    rst = 0; cyc = 0; last_tick = 0; per = 0;
    for (int k = 0; k < 21; k++) begin
      step();
      n_vec++;
      if (dvec() !== mvec()) begin
        n_bad++; $display("FAIL after_reset_model k=%0d got=%h exp=%h", k, dvec(), mvec());
      end
    end
    n_vec++;
    if (per !== 10 || cur_div !== W'(10)) begin
      n_bad++; $display("FAIL pend_discard got per=%0d div=%0d exp per=10 div=10", per, cur_div);
    end
  endtask

  task automatic test_random();
    apply_reset();
    en = 1;
    for (int k = 0; k < 800; k++) begin
      step();
      n_vec++;
      if (dvec() !== mvec()) begin
        n_bad++; $display("FAIL random_model k=%0d got=%h exp=%h", k, dvec(), mvec());
      end
      bus.div_valid = ($urandom_range(0, 3) == 0);
      bus.div_in    = W'($urandom_range(0, 9));
      if ($urandom_range(0, 39) == 0) en = ~en;
    end
    bus.div_valid = 0;
  endtask

`ifdef CLK_DIV_CTRL_ONESHOT_EN
  task automatic test_oneshot();
    apply_reset();
    oneshot = 1; en = 1;
    for (int k = 0; k <= 14; k++) begin
      step();
      n_vec++;
      if ({tick, running} !== {(k == 10), (k < 10)}) begin
        n_bad++; $display("FAIL oneshot k=%0d got=%b exp=%b", k, {tick, running}, {(k == 10), (k < 10)});
      end
    end
    en = 0;
    step();
    en = 1; oneshot = 0;
    step();
    n_vec++;
    if (running !== 1'b1) begin
      n_bad++; $display("FAIL oneshot_rearm got run=%b exp=1", running);
    end
    apply_reset();
  endtask
`endif

  initial begin
    bus.div_valid = 0;
    bus.div_in    = '0;
    test_reset();
    test_free_run();
    test_illegal();
    test_reprogram();
    test_odd_stop();
    test_reset_pend();
    test_random();
`ifdef CLK_DIV_CTRL_ONESHOT_EN
    test_oneshot();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
